// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with valid/ready flow control
// Optional parity output enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] f;
    logic             in_xfer;
    logic             out_xfer;
    logic             adv;

    always_comb begin
        case (op)
            3'b000:  f = ~a;
            3'b001:  f = a & b;
            3'b010:  f = a | b;
            3'b011:  f = a ^ b;
            3'b100:  f = ~(a & b);
            3'b101:  f = ~(a | b);
            3'b110:  f = ~(a ^ b);
            default: f = a;
        endcase
    end

    // Ready depends only on occupancy and out_ready, never on in_valid.
    assign in_ready  = ~v1 | ~v2 | out_ready;
    assign out_valid = v2;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v2 & out_ready;
    assign adv       = v1 & (~v2 | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            r1       <= '0;
            v2       <= 1'b0;
            y        <= '0;
            zero     <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity   <= 1'b0;
`endif
            done_cnt <= '0;
        end else begin
            if (in_xfer) begin
                v1 <= 1'b1;
                r1 <= f;
            end else if (adv) begin
                v1 <= 1'b0;
            end

            // Stage 2 only reloads on advance, so its payload holds while stalled.
            if (adv) begin
                v2     <= 1'b1;
                y      <= r1;
                zero   <= (r1 == '0);
`ifdef LOGIC_UNIT_PARITY_EN
                parity <= ^r1;
`endif
            end else if (out_xfer) begin
                v2 <= 1'b0;
            end

            if (out_xfer) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe (LOGIC_UNIT_PARITY_EN optional)
module tb_logic_unit_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         in_ready, out_valid, zero;
    logic [W-1:0] y;
    logic [15:0]  done_cnt;
    logic         in_ready2, out_valid2, zero2;
    logic [W-1:0] y2;
    logic [1:0]   done_cnt2;
`ifdef LOGIC_UNIT_PARITY_EN
    logic         parity, parity2;
`endif

    logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity(parity),
`endif
        .done_cnt(done_cnt)
    );

    logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .zero(zero2),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity(parity2),
`endif
        .done_cnt(done_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: FIFO of pending results; vis means the oldest one is presented at the output.
    logic [W-1:0] q[$];
    bit           vis;
    int unsigned  cnt;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         zero;
    } vec_t;
    vec_t tv[8];

    function automatic logic [W-1:0] f_ref(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & z;
            3'd2:    return x | z;
            3'd3:    return x ^ z;
            3'd4:    return ~(x & z);
            3'd5:    return ~(x | z);
            3'd6:    return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(vis));
        chk("out_valid2", 32'(out_valid2), 32'(vis));
        if (vis) begin
            chk("y", 32'(y), 32'(q[0]));
            chk("zero", 32'(zero), 32'(q[0] == '0));
`ifdef LOGIC_UNIT_PARITY_EN
            chk("parity", 32'(parity), 32'(^q[0]));
`endif
        end
        chk("done_cnt", 32'(done_cnt), 32'(16'(cnt)));
        chk("done_cnt2", 32'(done_cnt2), 32'(2'(cnt)));
    endtask

    task automatic model_clear();
        q.delete();
        vis = 1'b0;
        cnt = 0;
    endtask

    // Drive one cycle of inputs, check in_ready, take the edge, update model, check outputs.
    task automatic cycle(input logic iv, input logic [2:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic ordy);
        logic exp_rdy;
        in_valid  = iv;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        exp_rdy   = !(q.size() == 2 && !ordy);
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (vis && ordy) begin
            void'(q.pop_front());
            vis = 1'b0;
            cnt++;
        end
        if (q.size() > 0 && !vis) vis = 1'b1;
        if (iv && exp_rdy) q.push_back(f_ref(o, aa, bb));
        #1;
        check_out();
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
        chk("rst_parity", 32'(parity), 32'd0);
`endif
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held_y;
        logic [2:0]   bb_ops[4];
        logic [W-1:0] bb_exp[4];
        logic [1:0]   c2_exp[5];

        tv[0] = '{3'b000, 8'hA5, 8'h00, 8'h5A, 1'b0};
        tv[1] = '{3'b001, 8'hF0, 8'h0F, 8'h00, 1'b1};
        tv[2] = '{3'b110, 8'hF0, 8'h0F, 8'h00, 1'b1};
        tv[3] = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        tv[4] = '{3'b010, 8'h3C, 8'hC3, 8'hFF, 1'b0};
        tv[5] = '{3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0};
        tv[6] = '{3'b101, 8'h00, 8'h00, 8'hFF, 1'b0};
        tv[7] = '{3'b111, 8'h81, 8'h7E, 8'h81, 1'b0};
        bb_ops = '{3'b010, 3'b100, 3'b101, 3'b111};
        bb_exp = '{8'hFF, 8'hFF, 8'h00, 8'h3C};
        c2_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        model_clear();

        #1 rst_n = 1'b0;
        #12;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_y", 32'(y), 32'd0);
        chk("init_zero", 32'(zero), 32'd0);
        chk("init_done_cnt", 32'(done_cnt), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
        chk("init_parity", 32'(parity), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beats: result visible two edges after acceptance, counted on consumption.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tv[i].op, tv[i].a, tv[i].b, 1'b1);
            chk("lat_early", 32'(out_valid), 32'd0);
            cycle(1'b0, 3'b000, '0, '0, 1'b1);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_y", 32'(y), 32'(tv[i].y));
            chk("vec_zero", 32'(zero), 32'(tv[i].zero));
`ifdef LOGIC_UNIT_PARITY_EN
            chk("vec_parity", 32'(parity), 32'(^tv[i].y));
`endif
            cycle(1'b0, 3'b000, '0, '0, 1'b1);
            chk("vec_cnt", 32'(done_cnt), 32'(i + 1));
        end

        // Fill both stages, then reset mid-cycle.
        cycle(1'b1, 3'b000, 8'h11, 8'h00, 1'b0);
        cycle(1'b1, 3'b000, 8'h22, 8'h00, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        reset_pulse();
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        chk("no_stale", 32'(out_valid), 32'd0);
        cycle(1'b1, 3'b011, 8'h0F, 8'h33, 1'b1);
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        chk("post_rst_y", 32'(y), 32'h3C);
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        chk("post_rst_cnt", 32'(done_cnt), 32'd1);

        // Back-to-back beats with out_ready high.
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            cycle(i < 4, (i < 4) ? bb_ops[i] : 3'b000, 8'h3C, 8'hC3, 1'b1);
            if (i >= 1 && i <= 4) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_y", 32'(y), 32'(bb_exp[i-1]));
            end
        end
        chk("b2b_cnt", 32'(done_cnt), 32'd4);

        // Stall: two beats buffered, third held at the input, then drain in order.
        cycle(1'b1, 3'b111, 8'h01, 8'h00, 1'b0);
        cycle(1'b1, 3'b111, 8'h02, 8'h00, 1'b0);
        held_y = y;
        chk("stall_y0", 32'(held_y), 32'h01);
        cycle(1'b1, 3'b111, 8'h03, 8'h00, 1'b0);
        chk("stall_y1", 32'(y), 32'(held_y));
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 3'b111, 8'h03, 8'h00, 1'b1);
        chk("drain_y1", 32'(y), 32'h02);
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        chk("drain_y2", 32'(y), 32'h03);
        cycle(1'b0, 3'b000, '0, '0, 1'b1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Narrow counter wrap.
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'b000, 8'(i), '0, 1'b1);
            cycle(1'b0, 3'b000, '0, '0, 1'b1);
            cycle(1'b0, 3'b000, '0, '0, 1'b1);
            chk("cnt2_seq", 32'(done_cnt2), 32'(c2_exp[i]));
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom),
                  W'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
